// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running pixel/line counters, 1-based x/y for the pixel source,
// and a one-cycle output register stage that keeps RGB, syncs and frame_start aligned.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        h_wrap;
  logic        v_wrap;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;

  always_comb begin
    h_wrap  = (h_count == H_LAST);
    v_wrap  = (v_count == V_LAST);
    active  = (h_count < H_ACT) && (v_count < V_ACT);
    hsync_n = !((h_count >= HS_START) && (h_count < HS_END));
    // vsync depends on the line only, so it spans whole lines
    vsync_n = !((v_count >= VS_START) && (v_count < VS_END));
    x       = active ? h_count + 12'd1 : 12'd0;
    y       = active ? v_count + 12'd1 : 12'd0;
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      h_count <= 12'd0;
      v_count <= 12'd0;
    end else begin
      h_count <= h_wrap ? 12'd0 : h_count + 12'd1;
      if (h_wrap) begin
        v_count <= v_wrap ? 12'd0 : v_count + 12'd1;
      end
    end
  end

  // Single register stage: color is the source's answer for this cycle's x/y
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      vga_r       <= 1'b0;
      vga_g       <= 1'b0;
      vga_b       <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= active & color[2];
      vga_g       <= active & color[1];
      vga_b       <= active & color[0];
      vga_hs      <= hsync_n;
      vga_vs      <= vsync_n;
      frame_start <= (h_count == 12'd0) && (v_count == 12'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: a scaled-down raster instance for whole-frame walks and a default
// 640x480 instance for line timing; expectations come from the cycle index since reset.
module tb_vga_timing_generator;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 40, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int RST_POINT = (VA + VF) * HT + (HA + HF + 2);

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  color;
  logic [11:0] x, y, fx, fy;
  logic        vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start;
  logic        f_r, f_g, f_b, f_hs, f_vs, f_fs;

  int          total = 0;
  int          bad = 0;
  int          n;
  logic [2:0]  prev_color;
  bit          after_rst = 0;
  int          set_cnt = 0, vs_low_cnt = 0, b_cnt = 0, f_hs_low_cnt = 0, fs_cnt = 0;

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLOCK_25(clk), .reset(rst), .x(x), .y(y), .color(color),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  vga_timing_generator dut_full (
    .CLOCK_25(clk), .reset(rst), .x(fx), .y(fy), .color(color),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .vga_hs(f_hs), .vga_vs(f_vs), .frame_start(f_fs)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_reset_state();
    check("rst_x", x, 1);
    check("rst_y", y, 1);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_fs", frame_start, 0);
    check("rst_full_x", fx, 1);
    check("rst_full_y", fy, 1);
    check("rst_full_hs", f_hs, 1);
    check("rst_full_vs", f_vs, 1);
    check("rst_full_fs", f_fs, 0);
  endtask

  // n counts rising edges since reset release; registered outputs reflect state n-1
  task automatic check_all();
    int h, v, ph, pv, fh, fv, fph, fpv;
    logic pa, fpa;
    logic [2:0] exp_rgb, exp_frgb;
    h   = n % HT;          v   = (n / HT) % VT;
    ph  = (n - 1) % HT;    pv  = ((n - 1) / HT) % VT;
    fh  = n % 800;         fv  = (n / 800) % 525;
    fph = (n - 1) % 800;   fpv = ((n - 1) / 800) % 525;
    pa  = (ph < HA) && (pv < VA);
    fpa = (fph < 640) && (fpv < 480);
    exp_rgb  = pa ? prev_color : 3'b000;
    exp_frgb = fpa ? prev_color : 3'b000;

    check("x", x, (h < HA && v < VA) ? h + 1 : 0);
    check("y", y, (h < HA && v < VA) ? v + 1 : 0);
    check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
    check("hs", vga_hs, !(ph >= HA + HF && ph < HA + HF + HS));
    check("vs", vga_vs, !(pv >= VA + VF && pv < VA + VF + VS));
    check("fs", frame_start, ((n - 1) % FT) == 0);

    check("full_x", fx, (fh < 640 && fv < 480) ? fh + 1 : 0);
    check("full_y", fy, (fh < 640 && fv < 480) ? fv + 1 : 0);
    check("full_rgb", {f_r, f_g, f_b}, exp_frgb);
    check("full_hs", f_hs, !(fph >= 656 && fph < 752));
    check("full_vs", f_vs, !(fpv >= 490 && fpv < 492));
    check("full_fs", f_fs, ((n - 1) % 420000) == 0);

    if (!after_rst) begin
      if (n - 1 < FT && {vga_r, vga_g, vga_b} == 3'b111) set_cnt++;
      if (n - 1 < FT && !vga_vs) vs_low_cnt++;
      if (n - 1 >= FT && n - 1 < 2 * FT && vga_b) b_cnt++;
      if (n - 1 < 800 && !f_hs) f_hs_low_cnt++;
      if (n - 1 < 3 * FT && frame_start) fs_cnt++;
    end
  endtask

  // Frame 0: constant white; frame 1: blue only at the last visible pixel; then a pattern
  task automatic set_color();
    int h, v, f;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FT;
    if (f == 0) color = 3'b111;
    else if (f == 1) color = (h == HA - 1 && v == VA - 1) ? 3'b001 : 3'b000;
    else color = 3'((h + v) % 8);
  endtask

  task automatic step();
    prev_color = color;
    @(posedge clk);
    @(negedge clk);
    n++;
    check_all();
    set_color();
  endtask

  initial begin
    rst   = 1'b1;
    color = 3'b111;
    n     = 0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    repeat (3 * FT) step();

    check("white_pixels_per_frame", set_cnt, HA * VA);
    check("vs_low_cycles", vs_low_cnt, VS * HT);
    check("blue_pulse_count", b_cnt, 1);
    check("full_hs_low_cycles", f_hs_low_cnt, 96);
    check("frame_start_count", fs_cnt, 3);

    while ((n % FT) != RST_POINT) step();
    check("pre_rst_hs_low", vga_hs, 0);
    check("pre_rst_vs_low", vga_vs, 0);

    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    @(negedge clk);
    check_reset_state();

    rst       = 1'b0;
    n         = 0;
    after_rst = 1;
    color     = 3'b111;
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
